vector_vector_alu: RTL



---
 rtl/lebug_pkg.sv | 28 ++
 rtl/vv_lane_alu.sv | 30 +++
 rtl/vector_vector_alu.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/lebug_pkg.sv
// Shared encodings for the lebug vector stages: ALU ops, emit conditions,
// cache control and the order of firmware bytes in the config stream.
package lebug_pkg;

  localparam logic [7:0] OP_PASS = 8'd0;
  localparam logic [7:0] OP_ADD  = 8'd1;
  localparam logic [7:0] OP_SUB  = 8'd2;
  localparam logic [7:0] OP_MAX  = 8'd3;
  localparam logic [7:0] OP_MIN  = 8'd4;

  localparam logic [7:0] COND_ALWAYS = 8'd0;
  localparam logic [7:0] COND_EOF    = 8'd1;

  localparam logic [7:0] CACHE_WRITE = 8'd1;

  // Each chain consumes three config bytes, in this order.
  typedef enum logic [1:0] {
    SLOT_OP    = 2'd0,
    SLOT_COND  = 2'd1,
    SLOT_CACHE = 2'd2
  } slot_e;

  typedef enum logic {
    CFG_RUN  = 1'b0,
    CFG_LOAD = 1'b1
  } cfg_state_e;

endpackage

// File: rtl/vv_lane_alu.sv
// Single-lane combinational ALU: applies the chain op between the input lane
// and the accumulator lane; a beginning-of-frame beat yields the input unchanged.
module vv_lane_alu
  import lebug_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [7:0]            op,
  input  logic                  bof,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] acc,
  output logic [DATA_WIDTH-1:0] result
);

  // bof replaces the accumulator with the op identity, which reduces to a for every op
  always_comb begin
    result = a;
    if (!bof) begin
      case (op)
        OP_PASS: result = a;
        OP_ADD:  result = a + acc;
        OP_SUB:  result = a - acc;
        OP_MAX:  result = ($signed(a) >= $signed(acc)) ? a : acc;
        OP_MIN:  result = ($signed(a) <= $signed(acc)) ? a : acc;
        default: result = a;
      endcase
    end
  end

endmodule

// File: rtl/vector_vector_alu.sv
// Per-chain vector ALU stage: combines the incoming N-lane vector with a
// per-chain accumulator over a two-stage pipeline, with byte-serial firmware config.
module vector_vector_alu
  import lebug_pkg::*;
#(
  parameter int                      N                      = 8,
  parameter int                      DATA_WIDTH             = 32,
  parameter int                      MAX_CHAINS             = 4,
  parameter logic [7:0]              PERSONAL_CONFIG_ID     = 8'd1,
  parameter logic [8*MAX_CHAINS-1:0] INITIAL_FIRMWARE_OP    = '0,
  parameter logic [8*MAX_CHAINS-1:0] INITIAL_FIRMWARE_CACHE = '0,
  parameter logic [8*MAX_CHAINS-1:0] INITIAL_FIRMWARE_COND  = '0,
  localparam int                     CW = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             tracing,
  input  logic                             valid_in,
  input  logic                             eof_in,
  input  logic                             bof_in,
  input  logic [CW-1:0]                    chainId_in,
  input  logic [7:0]                       configId,
  input  logic [7:0]                       configData,
  input  logic [N-1:0][DATA_WIDTH-1:0]     vector_in,
  output logic [N-1:0][DATA_WIDTH-1:0]     vector_out,
  output logic [CW-1:0]                    chainId_out,
  output logic                             valid_out,
  output logic                             eof_out,
  output logic                             bof_out
);

  typedef logic [N-1:0][DATA_WIDTH-1:0] vec_t;

  localparam logic [CW-1:0] LAST_CHAIN = CW'(MAX_CHAINS - 1);

  vec_t       acc     [MAX_CHAINS];
  logic [7:0] fw_op   [MAX_CHAINS];
  logic [7:0] fw_cond [MAX_CHAINS];
  logic [7:0] fw_cache[MAX_CHAINS];

  cfg_state_e    cfg_state, cfg_state_next;
  logic [CW-1:0] cfg_chain, cfg_chain_next;
  slot_e         cfg_slot, cfg_slot_next;
  logic          cfg_we;

  logic          s1_valid, s1_eof, s1_bof;
  logic [CW-1:0] s1_chain;
  logic [7:0]    s1_op, s1_cond, s1_cache;
  vec_t          s1_vec, s1_operand;
  vec_t          result;

  logic accept, fire, write_back, forward;

  assign accept     = tracing && valid_in;
  assign fire       = tracing && s1_valid;
  assign write_back = fire && (s1_cache == CACHE_WRITE);
  assign forward    = write_back && (s1_chain == chainId_in);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_state <= CFG_RUN;
      cfg_chain <= '0;
      cfg_slot  <= SLOT_OP;
    end else begin
      cfg_state <= cfg_state_next;
      cfg_chain <= cfg_chain_next;
      cfg_slot  <= cfg_slot_next;
    end
  end

  // Bytes are only consumed while tracing is low; returning to tracing rewinds the slot index
  always_comb begin
    cfg_state_next = cfg_state;
    cfg_chain_next = cfg_chain;
    cfg_slot_next  = cfg_slot;
    cfg_we         = 1'b0;
    if (tracing) begin
      cfg_state_next = CFG_RUN;
      if (cfg_state == CFG_LOAD) begin
        cfg_chain_next = '0;
        cfg_slot_next  = SLOT_OP;
      end
    end else begin
      cfg_state_next = CFG_LOAD;
      if (configId == PERSONAL_CONFIG_ID) begin
        cfg_we = 1'b1;
        case (cfg_slot)
          SLOT_OP:   cfg_slot_next = SLOT_COND;
          SLOT_COND: cfg_slot_next = SLOT_CACHE;
          default: begin
            cfg_slot_next  = SLOT_OP;
            cfg_chain_next = (cfg_chain == LAST_CHAIN) ? '0 : cfg_chain + 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < MAX_CHAINS; c++) begin
        fw_op[c]    <= INITIAL_FIRMWARE_OP[8*c +: 8];
        fw_cond[c]  <= INITIAL_FIRMWARE_COND[8*c +: 8];
        fw_cache[c] <= INITIAL_FIRMWARE_CACHE[8*c +: 8];
      end
    end else if (cfg_we) begin
      case (cfg_slot)
        SLOT_OP:   fw_op[cfg_chain]    <= configData;
        SLOT_COND: fw_cond[cfg_chain]  <= configData;
        default:   fw_cache[cfg_chain] <= configData;
      endcase
    end
  end

  // A same-chain write-back in flight supersedes the stored accumulator
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_eof     <= 1'b0;
      s1_bof     <= 1'b0;
      s1_chain   <= '0;
      s1_op      <= '0;
      s1_cond    <= '0;
      s1_cache   <= '0;
      s1_vec     <= '0;
      s1_operand <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_eof     <= eof_in;
        s1_bof     <= bof_in;
        s1_chain   <= chainId_in;
        s1_op      <= fw_op[chainId_in];
        s1_cond    <= fw_cond[chainId_in];
        s1_cache   <= fw_cache[chainId_in];
        s1_vec     <= vector_in;
        s1_operand <= forward ? result : acc[chainId_in];
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    vv_lane_alu #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_lane (
      .op    (s1_op),
      .bof   (s1_bof),
      .a     (s1_vec[i]),
      .acc   (s1_operand[i]),
      .result(result[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < MAX_CHAINS; c++) begin
        acc[c] <= '0;
      end
    end else if (write_back) begin
      acc[s1_chain] <= result;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vector_out  <= '0;
      chainId_out <= '0;
      valid_out   <= 1'b0;
      eof_out     <= 1'b0;
      bof_out     <= 1'b0;
    end else begin
      valid_out <= fire && ((s1_cond == COND_ALWAYS) || s1_eof);
      eof_out   <= fire && s1_eof;
      bof_out   <= fire && s1_bof;
      if (fire) begin
        vector_out  <= result;
        chainId_out <= s1_chain;
      end
    end
  end

endmodule
